// File: rtl/jtag_pkg.sv
// Shared JTAG encodings: TAP state enum (IEEE 1149.1 Table 6-3) and the
// TAP next-state function used by the controller.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam tap_state_e TAP_RESET_STATE = TEST_LOGIC_RESET;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         n = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR  : CAPTURE_DR;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR:       n = tms ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR  : RUN_IDLE;
      CAPTURE_IR:       n = tms ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR  : RUN_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// Pin/chain-side bundle of the TAP controller. master = controller side.
// TAP_STATE_OUT_EN adds the tap_state debug signal.
interface tap_controller_if;
  logic       tms;
  logic       tdo_ir;
  logic       tdo_dr;
  logic       tdo;
  logic       tdo_en;
  logic       tck_ir;
  logic       tck_dr;
  logic       captureIR;
  logic       captureDR;
  logic       shiftDR;
  logic       updateIR;
  logic       updateDR;
  logic       tlr_n;
  logic       run_idle;
`ifdef TAP_STATE_OUT_EN
  logic [3:0] tap_state;

  modport master (
    input  tms, tdo_ir, tdo_dr,
    output tdo, tdo_en, tck_ir, tck_dr, captureIR, captureDR, shiftDR,
           updateIR, updateDR, tlr_n, run_idle, tap_state
  );
  modport slave (
    output tms, tdo_ir, tdo_dr,
    input  tdo, tdo_en, tck_ir, tck_dr, captureIR, captureDR, shiftDR,
           updateIR, updateDR, tlr_n, run_idle, tap_state
  );
`else
  modport master (
    input  tms, tdo_ir, tdo_dr,
    output tdo, tdo_en, tck_ir, tck_dr, captureIR, captureDR, shiftDR,
           updateIR, updateDR, tlr_n, run_idle
  );
  modport slave (
    output tms, tdo_ir, tdo_dr,
    input  tdo, tdo_en, tck_ir, tck_dr, captureIR, captureDR, shiftDR,
           updateIR, updateDR, tlr_n, run_idle
  );
`endif
endinterface

// File: rtl/tap_clk_gate.sv
// Glitch-free clock gate: enable flopped on negedge tck, ANDed with tck.
module tap_clk_gate (
  input  logic tck,
  input  logic tl_reset,
  input  logic en_i,
  output logic gclk_o
);
  logic en_q;

  // Enable only moves while tck is low, so the AND output cannot glitch.
  always_ff @(negedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en_i;
    end
  end

  assign gclk_o = tck & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR/DR strobes, gated clocks, TDO mux.
// Define TAP_STATE_OUT_EN to expose the raw state register as bus.tap_state.
module tap_controller
  import jtag_pkg::*;
(
  input  logic             tck,
  input  logic             tl_reset,
  tap_controller_if.master bus
);

  tap_state_e state_q;
  tap_state_e state_d;
  logic       ir_sel_s;
  logic       dr_sel_s;
  logic       tdo_q;
  logic       tdo_en_q;
  logic       update_ir_q;
  logic       update_dr_q;
  logic       tlr_n_q;

  assign state_d = tap_next(state_q, bus.tms);

  // TAP state register.
  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      state_q <= TAP_RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.captureIR = (state_q == CAPTURE_IR);
  assign bus.captureDR = (state_q == CAPTURE_DR);
  assign bus.shiftDR   = (state_q == SHIFT_DR);
  assign bus.run_idle  = (state_q == RUN_IDLE);

  // Negedge outputs: strobes settle half a TCK before the chain's next posedge.
  always_ff @(negedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      update_ir_q <= 1'b0;
      update_dr_q <= 1'b0;
      tlr_n_q     <= 1'b0;
      tdo_en_q    <= 1'b0;
      tdo_q       <= 1'b0;
    end else begin
      update_ir_q <= (state_q == UPDATE_IR);
      update_dr_q <= (state_q == UPDATE_DR);
      tlr_n_q     <= (state_q != TEST_LOGIC_RESET);
      tdo_en_q    <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
      case (state_q)
        SHIFT_IR: tdo_q <= bus.tdo_ir;
        SHIFT_DR: tdo_q <= bus.tdo_dr;
        default:  tdo_q <= tdo_q;
      endcase
    end
  end

  assign bus.updateIR = update_ir_q;
  assign bus.updateDR = update_dr_q;
  assign bus.tlr_n    = tlr_n_q;
  assign bus.tdo_en   = tdo_en_q;
  assign bus.tdo      = tdo_q;

  assign ir_sel_s = (state_q == CAPTURE_IR) || (state_q == SHIFT_IR);
  assign dr_sel_s = (state_q == CAPTURE_DR) || (state_q == SHIFT_DR);

  tap_clk_gate u_ir_gate (
    .tck      (tck),
    .tl_reset (tl_reset),
    .en_i     (ir_sel_s),
    .gclk_o   (bus.tck_ir)
  );

  tap_clk_gate u_dr_gate (
    .tck      (tck),
    .tl_reset (tl_reset),
    .en_i     (dr_sel_s),
    .gclk_o   (bus.tck_dr)
  );

`ifdef TAP_STATE_OUT_EN
  assign bus.tap_state = state_q;
`else
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Directed self-checking bench for tap_controller (tap_state walk when
// TAP_STATE_OUT_EN is defined).
module tb_tap_controller;
  import jtag_pkg::*;

  logic tck;
  logic tl_reset;
  int   checks;
  int   failures;

  int      ir_edges, dr_edges, upd_ir_cnt, upd_dr_cnt, cap_ir_cyc;
  longint  ir_rise_t, ir_fall_t;
  logic    ir_rise_tck;
  int      base_ir, base_dr, base_uir, base_udr, base_cap, dr_mid;

  bit         walk_tms [19];
  logic [3:0] walk_exp [19];

  tap_controller_if jtag ();

  tap_controller dut (
    .tck      (tck),
    .tl_reset (tl_reset),
    .bus      (jtag)
  );

  initial begin
    tck = 1'b0;
    forever #10 tck = ~tck;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  always @(posedge jtag.tck_ir) ir_edges++;
  always @(posedge jtag.tck_dr) dr_edges++;
  always @(posedge jtag.updateDR) upd_dr_cnt++;
  always @(posedge tck) if (jtag.captureIR === 1'b1) cap_ir_cyc++;
  always @(posedge jtag.updateIR) begin
    upd_ir_cnt++;
    ir_rise_t   = $time;
    ir_rise_tck = tck;
  end
  always @(negedge jtag.updateIR) ir_fall_t = $time;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One TAP cycle: drive tms, take the posedge, return just after the negedge.
  task automatic step(input logic t);
    jtag.tms = t;
    @(posedge tck);
    #1;
    @(negedge tck);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    ir_edges = 0; dr_edges = 0; upd_ir_cnt = 0; upd_dr_cnt = 0; cap_ir_cyc = 0;
    ir_rise_t = 0; ir_fall_t = 0; ir_rise_tck = 1'b1;
    walk_tms = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    walk_exp = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5, 4'h7, 4'h4,
                 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
    tl_reset    = 1'b0;
    jtag.tms    = 1'b1;
    jtag.tdo_ir = 1'b0;
    jtag.tdo_dr = 1'b0;

    // Reset values, sampled with tck low and again after a posedge under reset.
    #5;
    check("rst_tlr_n",     32'(jtag.tlr_n),     32'd0);
    check("rst_tdo",       32'(jtag.tdo),       32'd0);
    check("rst_tdo_en",    32'(jtag.tdo_en),    32'd0);
    check("rst_update_ir", 32'(jtag.updateIR),  32'd0);
    check("rst_update_dr", 32'(jtag.updateDR),  32'd0);
    check("rst_run_idle",  32'(jtag.run_idle),  32'd0);
    check("rst_capture",   32'({jtag.captureIR, jtag.captureDR, jtag.shiftDR}), 32'd0);
`ifdef TAP_STATE_OUT_EN
    check("rst_state",     32'(jtag.tap_state), 32'hF);
`endif
    @(posedge tck);
    #1;
    check("rst_gclk", 32'({jtag.tck_ir, jtag.tck_dr}), 32'd0);
    @(negedge tck);
    #1;
    tl_reset = 1'b1;

    // TLR -> RUN_IDLE, then 5 x tms=1 back to TLR.
    step(1'b0);
    check("ri_run_idle", 32'(jtag.run_idle), 32'd1);
    check("ri_tlr_n",    32'(jtag.tlr_n),    32'd1);
    repeat (5) step(1'b1);
    check("tlr5_tlr_n",    32'(jtag.tlr_n),    32'd0);
    check("tlr5_run_idle", 32'(jtag.run_idle), 32'd0);
    step(1'b0);

    // IR scan: 1,1 then capture + 5 shifts, then 1,1,0.
    base_ir = ir_edges; base_uir = upd_ir_cnt; base_cap = cap_ir_cyc;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("ir_capture_hi", 32'(jtag.captureIR), 32'd1);
    jtag.tdo_ir = 1'b1;
    step(1'b0);
    check("ir_capture_lo", 32'(jtag.captureIR), 32'd0);
    check("ir_tdo",        32'(jtag.tdo),       32'd1);
    check("ir_tdo_en",     32'(jtag.tdo_en),    32'd1);
    repeat (4) step(1'b0);
    step(1'b1);
    check("ir_exit1_tdo_en", 32'(jtag.tdo_en),       32'd0);
    check("ir_exit1_tdo",    32'(jtag.tdo),          32'd1);
    check("ir_tck_edges",    32'(ir_edges - base_ir), 32'd6);
    step(1'b1);
    check("ir_update_hi", 32'(jtag.updateIR), 32'd1);
    step(1'b0);
    check("ir_update_lo",    32'(jtag.updateIR),        32'd0);
    check("ir_update_cnt",   32'(upd_ir_cnt - base_uir), 32'd1);
    check("ir_update_width", 32'(ir_fall_t - ir_rise_t), 32'd20);
    check("ir_update_neg",   32'(ir_rise_tck),           32'd0);
    check("ir_cap_cycles",   32'(cap_ir_cyc - base_cap), 32'd1);
    check("ir_end_ri",       32'(jtag.run_idle),        32'd1);

    // tdo_dr outside a shift state must not reach tdo.
    jtag.tdo_dr = 1'b0;
    step(1'b0);
    check("tdo_hold_a", 32'(jtag.tdo), 32'd1);
    jtag.tdo_dr = 1'b1;
    step(1'b0);
    check("tdo_hold_b", 32'(jtag.tdo), 32'd1);
    jtag.tdo_ir = 1'b0;

    // DR scan with 3 pause cycles and a return to Shift-DR via Exit2-DR.
    base_dr = dr_edges; base_udr = upd_dr_cnt;
    step(1'b1);
    step(1'b0);
    check("dr_capture", 32'(jtag.captureDR), 32'd1);
    step(1'b0);
    check("dr_shift_a", 32'(jtag.shiftDR), 32'd1);
    check("dr_tdo",     32'(jtag.tdo),     32'd1);
    step(1'b0);
    step(1'b1);
    check("dr_exit1_shift", 32'(jtag.shiftDR), 32'd0);
    dr_mid = dr_edges - base_dr;
    check("dr_edges_pre", 32'(dr_mid), 32'd3);
    repeat (3) step(1'b0);
    check("dr_pause_shift", 32'(jtag.shiftDR), 32'd0);
    step(1'b1);
    check("dr_pause_silent", 32'(dr_edges - base_dr), 32'd3);
    step(1'b0);
    check("dr_shift_b", 32'(jtag.shiftDR), 32'd1);
    step(1'b1);
    step(1'b1);
    check("dr_update_hi", 32'(jtag.updateDR), 32'd1);
    step(1'b0);
    check("dr_update_lo",  32'(jtag.updateDR),         32'd0);
    check("dr_update_cnt", 32'(upd_dr_cnt - base_udr), 32'd1);
    check("dr_edges_all",  32'(dr_edges - base_dr),    32'd4);

    // Reset pulse in the middle of Shift-DR abandons the scan.
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("mid_shift", 32'(jtag.shiftDR), 32'd1);
    base_udr = upd_dr_cnt;
    tl_reset = 1'b0;
    #2;
    base_dr = dr_edges;
`ifdef TAP_STATE_OUT_EN
    check("mid_state", 32'(jtag.tap_state), 32'hF);
`endif
    check("mid_tck_dr", 32'(jtag.tck_dr),  32'd0);
    check("mid_shiftdr",32'(jtag.shiftDR), 32'd0);
    check("mid_tlr_n",  32'(jtag.tlr_n),   32'd0);
    check("mid_tdo_en", 32'(jtag.tdo_en),  32'd0);
    #2;
    tl_reset = 1'b1;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("mid_no_update", 32'(upd_dr_cnt - base_udr), 32'd0);
    check("mid_no_dr_clk", 32'(dr_edges - base_dr),    32'd0);
    check("mid_run_idle",  32'(jtag.run_idle),         32'd1);

`ifdef TAP_STATE_OUT_EN
    // Walk all 16 states starting from Test-Logic-Reset.
    repeat (5) step(1'b1);
    check("walk_start", 32'(jtag.tap_state), 32'hF);
    for (int i = 0; i < 19; i++) begin
      step(walk_tms[i]);
      check($sformatf("walk_%0d", i), 32'(jtag.tap_state), 32'(walk_exp[i]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
